// File: rtl/amp_seq.sv
// Class-D amplifier power-up, register config and mute sequencer.
// Drives enable/mute pins and issues I2C register writes to the amp.
module amp_seq #(
  parameter logic [6:0] DEV_ADDR = 7'h20,
  parameter int N_CFG = 2,
  parameter logic [16*N_CFG-1:0] CFG_TABLE = {8'h35, 8'h08, 8'h36, 8'h00},
  parameter int T_EN_CYC = 27000,
  parameter int T_MUTE_CYC = 27000,
  parameter int LOCK_CYC = 2700,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       audio_valid,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [6:0] m_dev,
  output logic [7:0] m_reg,
  output logic [7:0] m_data,
  input  logic       m_done,
  input  logic       m_nack,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic [2:0] state,
  output logic       fault
);

  localparam int M1 = (T_EN_CYC > T_MUTE_CYC) ? T_EN_CYC : T_MUTE_CYC;
  localparam int MAXC = (M1 > LOCK_CYC) ? M1 : LOCK_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(N_CFG + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    EN_WAIT    = 3'd1,
    CONFIG     = 3'd2,
    WAIT_AUDIO = 3'd3,
    PLAY       = 3'd4,
    MUTE_DOWN  = 3'd5,
    FAULT      = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] rty_q, rty_d;
  logic          busy_q, busy_d;
  logic          mv_d;
  logic          issue;
  logic [15:0]   ent;
  logic          nen_d, nmute_d, fault_d;

  assign m_dev = DEV_ADDR;
  assign state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rty_d   = rty_q;
    busy_d  = busy_q;
    mv_d    = m_valid;
    issue   = 1'b0;
    unique case (state_q)
      OFF: begin
        if (ena) begin
          state_d = EN_WAIT;
          cnt_d   = '0;
        end
      end
      EN_WAIT: begin
        if (!ena) begin
          state_d = OFF;
        end else if (cnt_q == CW'(T_EN_CYC - 1)) begin
          state_d = CONFIG;
          idx_d   = '0;
          rty_d   = '0;
          busy_d  = 1'b0;
          mv_d    = 1'b1;
          issue   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONFIG: begin
        // One transfer in flight: valid until accepted, then busy until done
        if (m_valid) begin
          if (m_ready) begin
            mv_d   = 1'b0;
            busy_d = 1'b1;
          end
        end else if (busy_q) begin
          if (m_done) begin
            busy_d = 1'b0;
            if (!ena) begin
              state_d = OFF;
            end else if (!m_nack) begin
              rty_d = '0;
              if (idx_q != IW'(N_CFG)) idx_d = idx_q + 1'b1;
              if (idx_q == IW'(N_CFG - 1)) begin
                state_d = WAIT_AUDIO;
                cnt_d   = '0;
              end else begin
                mv_d  = 1'b1;
                issue = 1'b1;
              end
            end else if (rty_q < RW'(MAX_RETRY)) begin
              rty_d = rty_q + 1'b1;
              mv_d  = 1'b1;
              issue = 1'b1;
            end else begin
              state_d = FAULT;
            end
          end
        end else if (!ena) begin
          state_d = OFF;
        end else begin
          mv_d  = 1'b1;
          issue = 1'b1;
        end
      end
      WAIT_AUDIO: begin
        if (!ena) begin
          state_d = OFF;
        end else if (cnt_q == CW'(LOCK_CYC)) begin
          state_d = PLAY;
        end else if (audio_valid) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      PLAY: begin
        if (!ena || !audio_valid) begin
          state_d = MUTE_DOWN;
          cnt_d   = '0;
        end
      end
      MUTE_DOWN: begin
        if (cnt_q == CW'(T_MUTE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ena ? WAIT_AUDIO : OFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FAULT: begin
        if (!ena) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    ent = '0;
    for (int i = 0; i < N_CFG; i++) begin
      if (idx_d == IW'(i)) ent = CFG_TABLE[16*i +: 16];
    end
  end

  // Pin levels follow the state being entered so they switch on that edge
  always_comb begin
    nen_d   = 1'b1;
    nmute_d = 1'b0;
    fault_d = 1'b0;
    unique case (state_d)
      EN_WAIT, CONFIG, WAIT_AUDIO, MUTE_DOWN: nen_d = 1'b0;
      PLAY: begin
        nen_d   = 1'b0;
        nmute_d = 1'b1;
      end
      FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OFF;
      cnt_q       <= '0;
      idx_q       <= '0;
      rty_q       <= '0;
      busy_q      <= 1'b0;
      m_valid     <= 1'b0;
      m_reg       <= '0;
      m_data      <= '0;
      amp_nenable <= 1'b1;
      amp_nmute   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rty_q       <= rty_d;
      busy_q      <= busy_d;
      m_valid     <= mv_d;
      amp_nenable <= nen_d;
      amp_nmute   <= nmute_d;
      fault       <= fault_d;
      if (issue) begin
        m_reg  <= ent[15:8];
        m_data <= ent[7:0];
      end
    end
  end

endmodule

// File: tb/tb_amp_seq.sv
// Directed bench for amp_seq: power-up, config writes, retry,
// fault, lock glitch, audio loss, disable mid-transfer, reset.
module tb_amp_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       audio_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_done = 1'b0;
  logic       m_nack = 1'b0;
  logic       m_valid;
  logic [6:0] m_dev;
  logic [7:0] m_reg;
  logic [7:0] m_data;
  logic       amp_nenable;
  logic       amp_nmute;
  logic [2:0] state;
  logic       fault;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  amp_seq #(
    .DEV_ADDR(7'h20),
    .N_CFG(2),
    .CFG_TABLE(32'h3508_3600),
    .T_EN_CYC(8),
    .T_MUTE_CYC(4),
    .LOCK_CYC(5),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ena(ena),
    .audio_valid(audio_valid),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_dev(m_dev),
    .m_reg(m_reg),
    .m_data(m_data),
    .m_done(m_done),
    .m_nack(m_nack),
    .amp_nenable(amp_nenable),
    .amp_nmute(amp_nmute),
    .state(state),
    .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept now, done pulse on the third edge after accept
  task automatic serve(input logic nack);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    m_done = 1'b1;
    m_nack = nack;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
  endtask

  // ena rises; expect EN_WAIT, then first m_valid exactly 8 edges later
  task automatic power_up(input string tag);
    ena = 1'b1;
    tick();
    chk({tag, "_st1"}, 32'(state), 32'd1);
    chk({tag, "_nen0"}, 32'(amp_nenable), 32'd0);
    repeat (7) tick();
    chk({tag, "_mv_early"}, 32'(m_valid), 32'd0);
    tick();
    chk({tag, "_mv"}, 32'(m_valid), 32'd1);
    chk({tag, "_st2"}, 32'(state), 32'd2);
  endtask

  initial begin
    // reset
    repeat (2) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_nen", 32'(amp_nenable), 32'd1);
    chk("rst_nmute", 32'(amp_nmute), 32'd0);
    chk("rst_mv", 32'(m_valid), 32'd0);
    chk("rst_reg", 32'(m_reg), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_off", 32'(state), 32'd0);

    // happy path; entry 0 is the low 16 bits of the table
    audio_valid = 1'b1;
    power_up("hp");
    chk("hp_dev", 32'(m_dev), 32'h20);
    chk("hp_reg0", 32'(m_reg), 32'h36);
    chk("hp_dat0", 32'(m_data), 32'h00);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("hp_mv_drop", 32'(m_valid), 32'd0);
    tick();
    tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("hp_mv1", 32'(m_valid), 32'd1);
    chk("hp_reg1", 32'(m_reg), 32'h35);
    chk("hp_dat1", 32'(m_data), 32'h08);
    serve(1'b0);
    chk("hp_st3", 32'(state), 32'd3);
    chk("hp_mv_idle", 32'(m_valid), 32'd0);
    repeat (5) tick();
    chk("hp_lock_early", 32'(amp_nmute), 32'd0);
    tick();
    chk("hp_st4", 32'(state), 32'd4);
    chk("hp_unmute", 32'(amp_nmute), 32'd1);

    // audio loss in PLAY
    audio_valid = 1'b0;
    tick();
    chk("loss_st5", 32'(state), 32'd5);
    chk("loss_mute", 32'(amp_nmute), 32'd0);
    repeat (3) tick();
    chk("loss_st5_hold", 32'(state), 32'd5);
    tick();
    chk("loss_st3", 32'(state), 32'd3);
    chk("loss_nen", 32'(amp_nenable), 32'd0);

    // lock glitch: high 4, low 1, high 5
    audio_valid = 1'b1;
    repeat (4) tick();
    audio_valid = 1'b0;
    tick();
    chk("gl_st3a", 32'(state), 32'd3);
    audio_valid = 1'b1;
    repeat (5) tick();
    chk("gl_st3b", 32'(state), 32'd3);
    chk("gl_mute", 32'(amp_nmute), 32'd0);
    tick();
    chk("gl_play", 32'(state), 32'd4);
    chk("gl_unmute", 32'(amp_nmute), 32'd1);

    // ena and audio drop together: mute first, then power down
    ena = 1'b0;
    audio_valid = 1'b0;
    tick();
    chk("dn_st5", 32'(state), 32'd5);
    chk("dn_mute", 32'(amp_nmute), 32'd0);
    repeat (3) tick();
    chk("dn_nen_hold", 32'(amp_nenable), 32'd0);
    tick();
    chk("dn_off", 32'(state), 32'd0);
    chk("dn_nen", 32'(amp_nenable), 32'd1);

    // NACK retry: entry 0 nacked twice then acked
    power_up("nr");
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("nr_early_done_mv", 32'(m_valid), 32'd1);
    chk("nr_early_done_reg", 32'(m_reg), 32'h36);
    serve(1'b1);
    chk("nr_re1_mv", 32'(m_valid), 32'd1);
    chk("nr_re1_reg", 32'(m_reg), 32'h36);
    serve(1'b1);
    chk("nr_re2_mv", 32'(m_valid), 32'd1);
    chk("nr_re2_dat", 32'(m_data), 32'h00);
    serve(1'b0);
    chk("nr_next_reg", 32'(m_reg), 32'h35);
    chk("nr_next_dat", 32'(m_data), 32'h08);
    chk("nr_fault", 32'(fault), 32'd0);
    serve(1'b0);
    chk("nr_st3", 32'(state), 32'd3);
    ena = 1'b0;
    tick();
    chk("nr_off", 32'(state), 32'd0);
    chk("nr_off_nen", 32'(amp_nenable), 32'd1);

    // fault after three NACKs
    power_up("ft");
    serve(1'b1);
    serve(1'b1);
    serve(1'b1);
    chk("ft_st6", 32'(state), 32'd6);
    chk("ft_fault", 32'(fault), 32'd1);
    chk("ft_nen", 32'(amp_nenable), 32'd1);
    chk("ft_mv", 32'(m_valid), 32'd0);
    tick();
    chk("ft_hold", 32'(state), 32'd6);
    ena = 1'b0;
    tick();
    chk("ft_off", 32'(state), 32'd0);
    chk("ft_clr", 32'(fault), 32'd0);

    // disable while a transfer is accepted but not done
    power_up("dc");
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    ena = 1'b0;
    tick();
    tick();
    chk("dc_mv", 32'(m_valid), 32'd0);
    chk("dc_st2", 32'(state), 32'd2);
    chk("dc_nen", 32'(amp_nenable), 32'd0);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("dc_off", 32'(state), 32'd0);
    chk("dc_off_nen", 32'(amp_nenable), 32'd1);
    tick();
    chk("dc_mv_after", 32'(m_valid), 32'd0);

    // reset mid-transfer drops m_valid
    power_up("rm");
    reset = 1'b1;
    tick();
    chk("rm_mv", 32'(m_valid), 32'd0);
    chk("rm_st", 32'(state), 32'd0);
    chk("rm_nen", 32'(amp_nenable), 32'd1);
    reset = 1'b0;
    ena = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
